// File: rtl/cdma_fifo_pkg.sv
// Shared sizing helpers and defaults for the CDMA parametrised FIFO family.
package cdma_fifo_pkg;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  localparam int DATA_W_DEF = 6;
  localparam int DEPTH_DEF  = 128;
  localparam int MAX_DEPTH  = 4096;
  localparam int CNT_MAX_W  = clog2_f(MAX_DEPTH) + 1;

  // Wide enough for any legal DEPTH so limit/count compares never truncate.
  typedef logic [CNT_MAX_W-1:0] cnt_t;

endpackage

// File: rtl/cdma_fifo_ram_rwsp.sv
// 1R1W storage: write at wa on we; re latches the read address, ore loads dout from it.
// No reset on the array or read path; the owning FIFO tracks validity.
module cdma_fifo_ram_rwsp
  import cdma_fifo_pkg::*;
#(
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = clog2_f(DEPTH)
) (
  input  logic              clk,
  input  logic [31:0]       pwrbus_ram_pd,
  input  logic [ADDR_W-1:0] wa,
  input  logic              we,
  input  logic [DATA_W-1:0] di,
  input  logic [ADDR_W-1:0] ra,
  input  logic              re,
  input  logic              ore,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              unused_pwr;

  // Behavioural array has no power modes; the bus is kept for the hard-macro swap.
  assign unused_pwr = ^pwrbus_ram_pd;

  always_comb begin
    ra_d   = re  ? ra        : ra_q;
    dout_d = ore ? mem[ra_q] : dout_q;
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= di;
    ra_q   <= ra_d;
    dout_q <= dout_d;
  end

  assign dout = dout_q;

endmodule

// File: rtl/cdma_param_fifo.sv
// Valid/ready FIFO over 1R1W RAM: two-stage read pipe (address latch, output register), write-to-read 2 cycles.
// wr_ready is registered from the post-edge count vs. the runtime limit; rd_req/rd_data hold while the consumer stalls.
module cdma_param_fifo
  import cdma_fifo_pkg::*;
#(
  parameter int  DATA_W    = DATA_W_DEF,
  parameter int  DEPTH     = DEPTH_DEF,
  parameter int  AFULL_LVL = DEPTH - 4,
  localparam int ADDR_W    = clog2_f(DEPTH),
  localparam int CNT_W     = clog2_f(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              wr_req,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_req,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  input  logic              flush,
  input  logic [CNT_W-1:0]  wr_limit,
  output logic [CNT_W-1:0]  count,
  output logic              almost_full,
  input  logic [31:0]       pwrbus_ram_pd
);

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t AFULL_C = cnt_t'(AFULL_LVL);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d, unread_q, unread_d;
  logic              wr_ready_q, wr_ready_d, rd_req_q, rd_req_d;
  logic              s1_vld_q, s1_vld_d, loaded_q, loaded_d;
  logic              accept, pop, ram_we, ram_re, ram_ore;
  cnt_t              lim_ext, eff_limit;
  logic [DATA_W-1:0] ram_dout;

  always_comb begin
    lim_ext   = cnt_t'(wr_limit);
    eff_limit = (lim_ext == '0 || lim_ext > DEPTH_C) ? DEPTH_C : lim_ext;
    accept    = wr_req & wr_ready_q;
    pop       = rd_req_q & rd_ready;
    // Output register refills when empty or being popped; stage 1 refills behind it.
    ram_ore   = s1_vld_q & (~rd_req_q | rd_ready) & ~flush;
    ram_re    = (unread_q != '0) & (~s1_vld_q | ram_ore) & ~flush;
    ram_we    = accept & ~flush;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    unread_d   = unread_q;
    s1_vld_d   = s1_vld_q;
    rd_req_d   = rd_req_q;
    wr_ready_d = wr_ready_q;
    loaded_d   = loaded_q | ram_ore;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      unread_d   = '0;
      s1_vld_d   = 1'b0;
      rd_req_d   = 1'b0;
      wr_ready_d = 1'b1;
    end else begin
      wr_ptr_d   = wr_ptr_q + ADDR_W'(ram_we);
      rd_ptr_d   = rd_ptr_q + ADDR_W'(ram_re);
      count_d    = count_q + CNT_W'(accept) - CNT_W'(pop);
      unread_d   = unread_q + CNT_W'(ram_we) - CNT_W'(ram_re);
      s1_vld_d   = ram_re | (s1_vld_q & ~ram_ore);
      rd_req_d   = ram_ore | (rd_req_q & ~pop);
      wr_ready_d = cnt_t'(count_d) < eff_limit;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      unread_q   <= '0;
      s1_vld_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      wr_ready_q <= 1'b1;
      loaded_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      unread_q   <= unread_d;
      s1_vld_q   <= s1_vld_d;
      rd_req_q   <= rd_req_d;
      wr_ready_q <= wr_ready_d;
      loaded_q   <= loaded_d;
    end
  end

  cdma_fifo_ram_rwsp #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk           (clk),
    .pwrbus_ram_pd (pwrbus_ram_pd),
    .wa            (wr_ptr_q),
    .we            (ram_we),
    .di            (wr_data),
    .ra            (rd_ptr_q),
    .re            (ram_re),
    .ore           (ram_ore),
    .dout          (ram_dout)
  );

  // RAM output has no reset; present zero until the first entry has been loaded.
  assign rd_data     = loaded_q ? ram_dout : '0;
  assign wr_ready    = wr_ready_q;
  assign rd_req      = rd_req_q;
  assign count       = count_q;
  assign almost_full = cnt_t'(count_q) >= AFULL_C;

endmodule

// File: tb/tb_cdma_param_fifo.sv
// Scoreboard bench: 128x6 instance for the directed scenarios, 4x64 instance for random backpressure and wrap.
`timescale 1ns/1ps
module tb_cdma_param_fifo;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_, wr_req, wr_ready, rd_req, rd_ready, flush, almost_full;
  logic [5:0]  wr_data, rd_data;
  logic [7:0]  wr_limit, count;
  logic [31:0] pwr;
  logic        b_wr_req, b_wr_ready, b_rd_req, b_rd_ready, b_flush, b_almost_full;
  logic [63:0] b_wr_data, b_rd_data;
  logic [2:0]  b_wr_limit, b_count;

  cdma_param_fifo #(.DATA_W(6), .DEPTH(128)) u_dut (
    .clk(clk), .reset_(reset_), .wr_req(wr_req), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_data(rd_data), .flush(flush),
    .wr_limit(wr_limit), .count(count), .almost_full(almost_full), .pwrbus_ram_pd(pwr)
  );

  cdma_param_fifo #(.DATA_W(64), .DEPTH(4), .AFULL_LVL(3)) u_dut4 (
    .clk(clk), .reset_(reset_), .wr_req(b_wr_req), .wr_ready(b_wr_ready), .wr_data(b_wr_data),
    .rd_req(b_rd_req), .rd_ready(b_rd_ready), .rd_data(b_rd_data), .flush(b_flush),
    .wr_limit(b_wr_limit), .count(b_count), .almost_full(b_almost_full), .pwrbus_ram_pd(pwr)
  );

  int          checks = 0;
  int          errors = 0;
  logic [5:0]  q[$];
  logic [63:0] qb[$];
  int          mcount = 0;
  int          b_pushes = 0;
  bit          acc_f, pop_f, b_acc_f, b_pop_f, b_stall;
  logic [63:0] b_stall_dat;

  // One clock: sample handshakes at negedge, update scoreboards, return just after posedge.
  task automatic clk_cycle();
    logic [5:0]  e;
    logic [63:0] eb;
    @(negedge clk);
    acc_f = 0; pop_f = 0; b_acc_f = 0; b_pop_f = 0;
    if (!reset_) begin
      q.delete(); qb.delete(); mcount = 0; b_stall = 0;
    end else begin
      if (flush) begin
        q.delete(); mcount = 0;
      end else begin
        if (rd_req && rd_ready) begin
          pop_f = 1; mcount--; checks++;
          if (q.size() == 0) begin
            errors++; $display("FAIL pop_order: got %h, want nothing (queue empty)", rd_data);
          end else begin
            e = q.pop_front();
            if (rd_data !== e) begin errors++; $display("FAIL pop_order: got %h want %h", rd_data, e); end
          end
        end
        if (wr_req && wr_ready) begin acc_f = 1; mcount++; q.push_back(wr_data); end
      end
      if (b_stall) begin
        checks++;
        if (b_rd_req !== 1'b1 || b_rd_data !== b_stall_dat) begin
          errors++; $display("FAIL b_stall_hold: got req=%b data=%h want req=1 data=%h", b_rd_req, b_rd_data, b_stall_dat);
        end
      end
      b_stall = b_rd_req && !b_rd_ready;
      b_stall_dat = b_rd_data;
      if (b_rd_req && b_rd_ready) begin
        b_pop_f = 1; checks++;
        if (qb.size() == 0) begin
          errors++; $display("FAIL b_pop_order: got %h, want nothing (queue empty)", b_rd_data);
        end else begin
          eb = qb.pop_front();
          if (b_rd_data !== eb) begin errors++; $display("FAIL b_pop_order: got %h want %h", b_rd_data, eb); end
        end
      end
      if (b_wr_req && b_wr_ready) begin b_acc_f = 1; b_pushes++; qb.push_back(b_wr_data); end
    end
    @(posedge clk); #1;
  endtask

  task automatic fill_to(input int k);
    rd_ready = 0; wr_req = 1;
    for (int i = 0; i < 300 && mcount < k; i++) begin
      clk_cycle();
      if (acc_f) wr_data = wr_data + 6'd1;
    end
    wr_req = 0;
  endtask

  task automatic drain();
    wr_req = 0; rd_ready = 1;
    for (int i = 0; i < 300 && mcount > 0; i++) clk_cycle();
    rd_ready = 0;
    checks++;
    if (count !== 8'd0) begin errors++; $display("FAIL drain_count: got %0d want 0", count); end
  endtask

  task automatic test_reset();
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b want 0", rd_req); end
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b want 0", almost_full); end
    checks++; if (rd_data !== 6'd0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    checks++; if (b_wr_ready !== 1'b1 || b_rd_req !== 1'b0) begin
      errors++; $display("FAIL reset_b: got wr_ready=%b rd_req=%b want 1/0", b_wr_ready, b_rd_req);
    end
  endtask

  task automatic test_latency();
    wr_data = 6'h2A; wr_req = 1;
    clk_cycle();
    wr_req = 0;
    checks++; if (rd_req !== 1'b0 || count !== 8'd1) begin
      errors++; $display("FAIL lat_t0: got rd_req=%b count=%0d want 0/1", rd_req, count);
    end
    clk_cycle();
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL lat_t1: got rd_req=%b want 0", rd_req); end
    clk_cycle();
    checks++; if (rd_req !== 1'b1 || rd_data !== 6'h2A) begin
      errors++; $display("FAIL lat_t2: got rd_req=%b data=%h want 1/2a", rd_req, rd_data);
    end
    rd_ready = 1;
    clk_cycle();
    rd_ready = 0;
    checks++; if (count !== 8'd0 || rd_req !== 1'b0) begin
      errors++; $display("FAIL lat_pop: got count=%0d rd_req=%b want 0/0", count, rd_req);
    end
  endtask

  task automatic test_fill_full();
    int n, popped, gaps;
    bit started;
    n = 0; wr_limit = 0; rd_ready = 0; wr_req = 1; wr_data = 0;
    for (int i = 0; i < 140; i++) begin
      clk_cycle();
      if (acc_f) begin n++; wr_data = wr_data + 6'd1; end
      checks++;
      if (count !== 8'(n) || almost_full !== (n >= 124)) begin
        errors++; $display("FAIL fill_cnt_af: got count=%0d af=%b want %0d/%b", count, almost_full, n, n >= 124);
      end
    end
    wr_req = 0;
    checks++; if (n != 128 || wr_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full: got accepts=%0d wr_ready=%b want 128/0", n, wr_ready);
    end
    popped = 0; gaps = 0; started = 0; rd_ready = 1;
    for (int i = 0; i < 300 && popped < 128; i++) begin
      clk_cycle();
      if (pop_f) begin popped++; started = 1; end else if (started) gaps++;
    end
    rd_ready = 0;
    checks++; if (popped != 128 || gaps != 0) begin
      errors++; $display("FAIL fill_drain: got pops=%0d gaps=%0d want 128/0", popped, gaps);
    end
    checks++; if (count !== 8'd0 || rd_req !== 1'b0) begin
      errors++; $display("FAIL fill_empty: got count=%0d rd_req=%b want 0/0", count, rd_req);
    end
  endtask

  task automatic test_limit();
    int resumed;
    wr_limit = 16; rd_ready = 0; wr_req = 1;
    for (int i = 0; i < 30; i++) begin
      clk_cycle();
      if (acc_f) wr_data = wr_data + 6'd1;
    end
    checks++; if (count !== 8'd16 || wr_ready !== 1'b0) begin
      errors++; $display("FAIL limit16: got count=%0d wr_ready=%b want 16/0", count, wr_ready);
    end
    wr_limit = 8; rd_ready = 1; resumed = 0;
    for (int i = 0; i < 25; i++) begin
      clk_cycle();
      if (acc_f) begin resumed++; wr_data = wr_data + 6'd1; end
      checks++;
      if (wr_ready !== (mcount < 8) || count !== 8'(mcount)) begin
        errors++; $display("FAIL limit8: got wr_ready=%b count=%0d want %b/%0d", wr_ready, count, mcount < 8, mcount);
      end
    end
    checks++; if (resumed == 0) begin errors++; $display("FAIL limit_resume: got 0 accepts want >0"); end
    wr_limit = 0;
    drain();
  endtask

  task automatic test_steady(input int k);
    int bad;
    fill_to(k);
    repeat (4) clk_cycle();
    wr_req = 1; rd_ready = 1; bad = 0;
    repeat (1000) begin
      clk_cycle();
      if (!(acc_f && pop_f)) bad++;
      if (acc_f) wr_data = wr_data + 6'd1;
    end
    checks++; if (bad != 0 || count !== 8'(k) || wr_ready !== 1'b1) begin
      errors++; $display("FAIL steady_%0d: got bubbles=%0d count=%0d wr_ready=%b want 0/%0d/1", k, bad, count, wr_ready, k);
    end
    drain();
  endtask

  task automatic test_flush();
    fill_to(50);
    flush = 1; wr_req = 1; rd_ready = 1;
    clk_cycle();
    flush = 0; wr_req = 0; rd_ready = 0;
    checks++; if (count !== 8'd0 || rd_req !== 1'b0 || wr_ready !== 1'b1) begin
      errors++; $display("FAIL flush: got count=%0d rd_req=%b wr_ready=%b want 0/0/1", count, rd_req, wr_ready);
    end
    wr_data = 6'h15; wr_req = 1;
    clk_cycle();
    wr_req = 0;
    for (int i = 0; i < 10 && !rd_req; i++) clk_cycle();
    checks++; if (rd_req !== 1'b1 || rd_data !== 6'h15) begin
      errors++; $display("FAIL flush_first: got rd_req=%b data=%h want 1/15", rd_req, rd_data);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    fill_to(30);
    reset_ = 0;
    #1;
    checks++; if (wr_ready !== 1'b1 || rd_req !== 1'b0 || count !== 8'd0 || almost_full !== 1'b0 || rd_data !== 6'd0) begin
      errors++; $display("FAIL reset_mid: got wr_ready=%b rd_req=%b count=%0d af=%b data=%h want 1/0/0/0/0",
                        wr_ready, rd_req, count, almost_full, rd_data);
    end
    q.delete(); qb.delete(); mcount = 0;
    repeat (2) clk_cycle();
    reset_ = 1;
    clk_cycle();
    wr_data = 6'h3F; wr_req = 1;
    clk_cycle();
    wr_req = 0;
    for (int i = 0; i < 10 && !rd_req; i++) clk_cycle();
    checks++; if (rd_req !== 1'b1 || rd_data !== 6'h3F) begin
      errors++; $display("FAIL reset_after: got rd_req=%b data=%h want 1/3f", rd_req, rd_data);
    end
    drain();
  endtask

  task automatic test_random_b();
    b_wr_req = 0; b_rd_ready = 0; b_pushes = 0;
    b_wr_data = {$urandom(), $urandom()};
    for (int i = 0; i < 300; i++) begin
      if (!b_wr_req || b_acc_f) begin
        b_wr_data = {$urandom(), $urandom()};
        b_wr_req = ($urandom_range(0, 3) != 0);
      end
      b_rd_ready = ($urandom_range(0, 2) == 0);
      clk_cycle();
    end
    b_wr_req = 0; b_rd_ready = 1;
    for (int i = 0; i < 20 && qb.size() != 0; i++) clk_cycle();
    b_rd_ready = 0;
    checks++; if (b_pushes < 16) begin errors++; $display("FAIL b_wrap: got %0d pushes want >=16", b_pushes); end
    checks++; if (qb.size() != 0 || b_count !== 3'd0 || b_rd_req !== 1'b0) begin
      errors++; $display("FAIL b_drain: got left=%0d count=%0d rd_req=%b want 0/0/0", qb.size(), b_count, b_rd_req);
    end
  endtask

  initial begin
    reset_ = 0; wr_req = 0; rd_ready = 0; flush = 0; wr_limit = 0; wr_data = 0; pwr = 0;
    b_wr_req = 0; b_rd_ready = 0; b_flush = 0; b_wr_limit = 0; b_wr_data = 0;
    acc_f = 0; pop_f = 0; b_acc_f = 0; b_pop_f = 0; b_stall = 0; b_stall_dat = 0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset_ = 1;
    repeat (2) clk_cycle();
    test_latency();
    test_fill_full();
    test_limit();
    test_steady(3);
    test_steady(127);
    test_flush();
    test_reset_mid();
    test_random_b();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
